// File: rtl/gprf_wb_unit_pkg.sv
// ----------------------------------------------------------------------------
// gprf_wb_unit_pkg
// Shared constants and types for the GPRF writeback unit.
//   XLEN        : result / write-port data width
//   REG_ADDR_W  : register index width
//   NREGS       : number of architectural registers (busy vector width)
//   wb_entry_t  : one pending register write {rd, data}
// ----------------------------------------------------------------------------
package gprf_wb_unit_pkg;

   localparam int XLEN           = 32;
   localparam int REG_ADDR_W     = 5;
   localparam int NREGS          = 32;
   localparam int LQ_DEPTH_DEF   = 4;
   localparam int STARVE_MAX_DEF = 2;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_entry_t;

   localparam int WB_ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/gprf_wb_lq.sv
// ----------------------------------------------------------------------------
// gprf_wb_lq
// Synchronous FIFO that buffers load returns until they win the write port.
//   clk, rst_n : clock, synchronous active-low reset (empties the queue)
//   push       : write push_data at the tail (caller never pushes when full)
//   pop        : drop the head entry (caller never pops when empty)
//   head       : current head entry
//   full/empty : occupancy flags
//   count      : number of valid entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// A pushed entry is only visible at head from the following cycle.
// ----------------------------------------------------------------------------
module gprf_wb_lq #(
   parameter int W     = 37,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic [W-1:0]             head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage needs no reset: entries are only read while cnt says they are valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign head  = mem[rd_ptr];
   assign full  = (cnt == CW'(DEPTH));
   assign empty = (cnt == '0);
   assign count = cnt;

endmodule

// File: rtl/gprf_wb_unit.sv
// ----------------------------------------------------------------------------
// gprf_wb_unit
// Writeback driver for the general-purpose register file write port.
//   clk, rst_n              : clock, synchronous active-low reset
//   alu_valid/ready/rd/data : ALU result offer; ready is the same-cycle grant
//   lsu_valid/ready/rd/data : load return offer; ready = load queue has space
//   iss_valid, iss_rd       : issued instruction with a destination register
//   we, outputReg, data     : registered register-file write (sampled on negedge)
//   busy                    : bit r set while a write to register r is pending
//
// Handshake: a transfer on either input channel happens in a cycle where
// valid and ready are both high at the rising edge; ready never depends on
// anything later in the cycle and valid may be withdrawn only after a transfer.
//
// Arbitration per cycle: a starved ALU (waited STARVE_MAX cycles) wins first,
// otherwise the load queue head, otherwise the ALU.
// ----------------------------------------------------------------------------
module gprf_wb_unit
   import gprf_wb_unit_pkg::*;
#(
   parameter int LQ_DEPTH   = LQ_DEPTH_DEF,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  alu_valid,
   output logic                  alu_ready,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [XLEN-1:0]       alu_data,
   input  logic                  lsu_valid,
   output logic                  lsu_ready,
   input  logic [REG_ADDR_W-1:0] lsu_rd,
   input  logic [XLEN-1:0]       lsu_data,
   input  logic                  iss_valid,
   input  logic [REG_ADDR_W-1:0] iss_rd,
   output logic                  we,
   output logic [REG_ADDR_W-1:0] outputReg,
   output logic [XLEN-1:0]       data,
   output logic [NREGS-1:0]      busy
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam int CW = $clog2(LQ_DEPTH) + 1;

   logic [SW-1:0]    starve_cnt;
   logic             starved;
   wb_entry_t        lq_in;
   wb_entry_t        lq_head;
   wb_entry_t        win;
   logic             lq_full;
   logic             lq_empty;
   logic [CW-1:0]    lq_count;
   logic             lq_push;
   logic             grant_alu;
   logic             grant_lq;
   logic             grant;
   logic [NREGS-1:0] busy_next;

   assign starved   = (starve_cnt == SW'(STARVE_MAX));
   // A same-cycle pop does not open a slot for a same-cycle push.
   assign lsu_ready = rst_n && (lq_count != CW'(LQ_DEPTH));
   assign lq_push   = lsu_valid && lsu_ready;
   assign lq_in     = '{rd: lsu_rd, data: lsu_data};

   gprf_wb_lq #(
      .W     (WB_ENTRY_W),
      .DEPTH (LQ_DEPTH)
   ) u_lq (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (lq_push),
      .push_data (lq_in),
      .pop       (grant_lq),
      .head      (lq_head),
      .full      (lq_full),
      .empty     (lq_empty),
      .count     (lq_count)
   );

   always_comb begin
      grant_alu = 1'b0;
      grant_lq  = 1'b0;
      win       = '0;
      // Nothing is granted while reset is held.
      if (rst_n) begin
         if (starved && alu_valid) grant_alu = 1'b1;
         else if (!lq_empty)       grant_lq  = 1'b1;
         else if (alu_valid)       grant_alu = 1'b1;
      end
      if (grant_alu)     win = '{rd: alu_rd, data: alu_data};
      else if (grant_lq) win = lq_head;
   end

   assign grant     = grant_alu || grant_lq;
   assign alu_ready = grant_alu;

   // Clear for the retiring write first so a same-cycle issue to the same
   // register leaves the bit set for the new writer.
   always_comb begin
      busy_next = busy;
      if (grant && (win.rd != '0)) busy_next[win.rd] = 1'b0;
      if (iss_valid && (iss_rd != '0)) busy_next[iss_rd] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         starve_cnt <= '0;
         we         <= 1'b0;
         outputReg  <= '0;
         data       <= '0;
         busy       <= '0;
      end else begin
         if (!alu_valid || grant_alu) starve_cnt <= '0;
         else if (!starved)           starve_cnt <= starve_cnt + 1'b1;

         if (grant) begin
            we        <= (win.rd != '0);
            outputReg <= win.rd;
            data      <= win.data;
         end else begin
            we <= 1'b0;
         end

         busy <= busy_next;
      end
   end

   a_full_matches_count: assert property (@(posedge clk)
      lq_full == (lq_count == CW'(LQ_DEPTH)));

endmodule

// File: tb/tb_gprf_wb_unit.sv
// ----------------------------------------------------------------------------
// tb_gprf_wb_unit
// Directed scenarios plus randomized traffic against a queue-based reference
// model of the writeback unit.
// ----------------------------------------------------------------------------
module tb_gprf_wb_unit;
   import gprf_wb_unit_pkg::*;

   localparam int LQ_DEPTH   = 4;
   localparam int STARVE_MAX = 2;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic                  alu_valid = 1'b0;
   logic                  alu_ready;
   logic [REG_ADDR_W-1:0] alu_rd    = '0;
   logic [XLEN-1:0]       alu_data  = '0;
   logic                  lsu_valid = 1'b0;
   logic                  lsu_ready;
   logic [REG_ADDR_W-1:0] lsu_rd    = '0;
   logic [XLEN-1:0]       lsu_data  = '0;
   logic                  iss_valid = 1'b0;
   logic [REG_ADDR_W-1:0] iss_rd    = '0;
   logic                  we;
   logic [REG_ADDR_W-1:0] outputReg;
   logic [XLEN-1:0]       data;
   logic [NREGS-1:0]      busy;

   gprf_wb_unit #(
      .LQ_DEPTH   (LQ_DEPTH),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .alu_valid (alu_valid),
      .alu_ready (alu_ready),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .lsu_valid (lsu_valid),
      .lsu_ready (lsu_ready),
      .lsu_rd    (lsu_rd),
      .lsu_data  (lsu_data),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .we        (we),
      .outputReg (outputReg),
      .data      (data),
      .busy      (busy)
   );

   int errors = 0;
   int checks = 0;

   // ---------------- reference model ----------------
   logic [REG_ADDR_W+XLEN-1:0] exp_q[$];
   int                         m_starve  = 0;
   logic [NREGS-1:0]           m_busy    = '0;
   logic                       m_we      = 1'b0;
   logic [REG_ADDR_W-1:0]      m_reg     = '0;
   logic [XLEN-1:0]            m_data    = '0;
   logic                       m_alu_rdy = 1'b0;
   logic                       m_lsu_rdy = 1'b0;
   logic                       m_take_q  = 1'b0;

   // Decisions for the current cycle, from current inputs and model state.
   task automatic model_comb();
      if (!rst_n) begin
         m_alu_rdy = 1'b0;
         m_lsu_rdy = 1'b0;
         m_take_q  = 1'b0;
      end else begin
         m_lsu_rdy = (exp_q.size() < LQ_DEPTH);
         m_alu_rdy = alu_valid && ((m_starve >= STARVE_MAX) || (exp_q.size() == 0));
         m_take_q  = !m_alu_rdy && (exp_q.size() != 0);
      end
   endtask

   // State update at the rising edge, using the decisions from model_comb.
   task automatic model_seq();
      logic [REG_ADDR_W-1:0] grd;
      logic [XLEN-1:0]       gd;
      grd = '0;
      gd  = '0;
      if (!rst_n) begin
         exp_q.delete();
         m_starve = 0;
         m_busy   = '0;
         m_we     = 1'b0;
         m_reg    = '0;
         m_data   = '0;
      end else begin
         if (m_alu_rdy) begin
            grd = alu_rd;
            gd  = alu_data;
         end else if (m_take_q) begin
            {grd, gd} = exp_q.pop_front();
         end
         if (m_alu_rdy || m_take_q) begin
            m_we   = (grd != 0);
            m_reg  = grd;
            m_data = gd;
            if (grd != 0) m_busy[grd] = 1'b0;
         end else begin
            m_we = 1'b0;
         end
         if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
         if (lsu_valid && m_lsu_rdy) exp_q.push_back({lsu_rd, lsu_data});
         if (!alu_valid || m_alu_rdy) m_starve = 0;
         else if (m_starve < STARVE_MAX) m_starve = m_starve + 1;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic settle();
      @(negedge clk);
      model_comb();
   endtask

   task automatic step_edge();
      @(posedge clk);
      model_seq();
      #1;
   endtask

   task automatic drive_idle();
      alu_valid = 1'b0;
      lsu_valid = 1'b0;
      iss_valid = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      drive_idle();
      settle();
      step_edge();
      rst_n = 1'b1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n     = 1'b0;
      alu_valid = 1'b1;
      alu_rd    = 5'd9;
      alu_data  = 32'hA5A5_0009;
      lsu_valid = 1'b1;
      lsu_rd    = 5'd4;
      lsu_data  = 32'h0000_0044;
      iss_valid = 1'b1;
      iss_rd    = 5'd3;
      for (int i = 0; i < 2; i++) begin
         settle();
         checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL rst_alu_ready: got %b want 0", alu_ready); end
         checks++; if (lsu_ready !== 1'b0) begin errors++; $display("FAIL rst_lsu_ready: got %b want 0", lsu_ready); end
         checks++; if (we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", we); end
         checks++; if (busy !== '0) begin errors++; $display("FAIL rst_busy: got %h want 0", busy); end
         checks++; if (outputReg !== '0) begin errors++; $display("FAIL rst_outputReg: got %0d want 0", outputReg); end
         checks++; if (data !== '0) begin errors++; $display("FAIL rst_data: got %h want 0", data); end
         step_edge();
      end
      rst_n     = 1'b1;
      lsu_valid = 1'b0;
      iss_valid = 1'b0;
      settle();
      checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL rel_alu_ready: got %b want 1", alu_ready); end
      checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL rel_lsu_ready: got %b want 1", lsu_ready); end
      step_edge();
      alu_valid = 1'b0;
      settle();
      checks++; if (we !== 1'b1 || outputReg !== 5'd9 || data !== 32'hA5A5_0009) begin
         errors++; $display("FAIL rel_first_write: got we=%b reg=%0d data=%h want 1/9/a5a50009", we, outputReg, data);
      end
      step_edge();
   endtask

   task automatic test_alu_only();
      apply_reset();
      iss_valid = 1'b1;
      iss_rd    = 5'd5;
      settle();
      step_edge();
      iss_valid = 1'b0;
      alu_valid = 1'b1;
      alu_rd    = 5'd5;
      alu_data  = 32'hDEAD_BEEF;
      settle();
      checks++; if (busy[5] !== 1'b1) begin errors++; $display("FAIL alu_busy_set: got %b want 1", busy[5]); end
      checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL alu_ready: got %b want 1", alu_ready); end
      step_edge();
      alu_valid = 1'b0;
      settle();
      checks++; if (we !== 1'b1 || outputReg !== 5'd5 || data !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL alu_write: got we=%b reg=%0d data=%h want 1/5/deadbeef", we, outputReg, data);
      end
      checks++; if (busy[5] !== 1'b0) begin errors++; $display("FAIL alu_busy_clear: got %b want 0", busy[5]); end
      step_edge();
      settle();
      checks++; if (we !== 1'b0 || data !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL alu_hold: got we=%b data=%h want 0/deadbeef", we, data);
      end
      step_edge();
   endtask

   task automatic test_queue_fill();
      int first_full;
      int prev_load;
      first_full = -1;
      prev_load  = -1;
      apply_reset();
      alu_valid = 1'b1;
      lsu_valid = 1'b1;
      alu_rd    = 5'd2;
      lsu_rd    = 5'd3;
      for (int i = 0; i < 16; i++) begin
         alu_data = 32'hA000_0000 + i;
         lsu_data = 32'h1000_0000 + i;
         settle();
         checks++; if (alu_ready !== m_alu_rdy) begin errors++; $display("FAIL qf_alu_ready cyc %0d: got %b want %b", i, alu_ready, m_alu_rdy); end
         checks++; if (alu_ready !== ((i % 3) == 0)) begin errors++; $display("FAIL qf_alu_third cyc %0d: got %b", i, alu_ready); end
         checks++; if (lsu_ready !== m_lsu_rdy) begin errors++; $display("FAIL qf_lsu_ready cyc %0d: got %b want %b", i, lsu_ready, m_lsu_rdy); end
         checks++; if (we !== m_we || outputReg !== m_reg || data !== m_data) begin
            errors++; $display("FAIL qf_write cyc %0d: got %b/%0d/%h want %b/%0d/%h", i, we, outputReg, data, m_we, m_reg, m_data);
         end
         if (we === 1'b1 && outputReg === 5'd3) begin
            checks++; if (int'(data[15:0]) <= prev_load) begin errors++; $display("FAIL qf_order cyc %0d: got %h after %0d", i, data, prev_load); end
            prev_load = int'(data[15:0]);
         end
         if (lsu_ready === 1'b0 && first_full < 0) first_full = i;
         step_edge();
      end
      checks++; if (first_full != 10) begin errors++; $display("FAIL qf_first_full: got cycle %0d want 10", first_full); end
      drive_idle();
      for (int i = 0; i < 8; i++) begin
         settle();
         checks++; if (we !== m_we || outputReg !== m_reg || data !== m_data) begin
            errors++; $display("FAIL qf_drain cyc %0d: got %b/%0d/%h want %b/%0d/%h", i, we, outputReg, data, m_we, m_reg, m_data);
         end
         step_edge();
      end
      settle();
      checks++; if (we !== 1'b0 || lsu_ready !== 1'b1) begin errors++; $display("FAIL qf_drained: got we=%b lsu_ready=%b want 0/1", we, lsu_ready); end
      step_edge();
   endtask

   task automatic test_rd_zero();
      apply_reset();
      iss_valid = 1'b1;
      iss_rd    = 5'd3;
      settle();
      step_edge();
      iss_valid = 1'b0;
      alu_valid = 1'b1;
      alu_rd    = 5'd0;
      alu_data  = 32'h0000_1234;
      settle();
      checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL rd0_ready: got %b want 1", alu_ready); end
      step_edge();
      alu_valid = 1'b0;
      settle();
      checks++; if (we !== 1'b0) begin errors++; $display("FAIL rd0_we: got %b want 0", we); end
      checks++; if (busy !== 32'h0000_0008) begin errors++; $display("FAIL rd0_busy: got %h want 00000008", busy); end
      checks++; if (data !== 32'h0000_1234 || outputReg !== 5'd0) begin errors++; $display("FAIL rd0_regs: got %0d/%h want 0/1234", outputReg, data); end
      step_edge();
   endtask

   task automatic test_set_clear();
      apply_reset();
      iss_valid = 1'b1;
      iss_rd    = 5'd7;
      settle();
      step_edge();
      alu_valid = 1'b1;
      alu_rd    = 5'd7;
      alu_data  = 32'h0000_0077;
      settle();
      checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL sc_ready: got %b want 1", alu_ready); end
      step_edge();
      drive_idle();
      settle();
      checks++; if (we !== 1'b1 || outputReg !== 5'd7) begin errors++; $display("FAIL sc_write: got we=%b reg=%0d want 1/7", we, outputReg); end
      checks++; if (busy !== 32'h0000_0080) begin errors++; $display("FAIL sc_busy: got %h want 00000080", busy); end
      step_edge();
   endtask

   task automatic test_reset_mid();
      apply_reset();
      alu_valid = 1'b1;
      lsu_valid = 1'b1;
      iss_valid = 1'b1;
      for (int i = 0; i < 40 && exp_q.size() != 3; i++) begin
         iss_rd   = REG_ADDR_W'($urandom_range(1, 31));
         alu_rd   = REG_ADDR_W'($urandom_range(1, 31));
         alu_data = $urandom;
         lsu_rd   = REG_ADDR_W'($urandom_range(1, 31));
         lsu_data = $urandom;
         settle();
         checks++; if (busy !== m_busy || we !== m_we || outputReg !== m_reg) begin
            errors++; $display("FAIL rm_fill cyc %0d: got busy=%h we=%b reg=%0d want %h/%b/%0d", i, busy, we, outputReg, m_busy, m_we, m_reg);
         end
         step_edge();
      end
      rst_n = 1'b0;
      drive_idle();
      settle();
      step_edge();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         settle();
         checks++; if (we !== 1'b0 || busy !== '0 || lsu_ready !== 1'b1) begin
            errors++; $display("FAIL rm_after cyc %0d: got we=%b busy=%h lsu_ready=%b want 0/0/1", i, we, busy, lsu_ready);
         end
         step_edge();
      end
      alu_valid = 1'b1;
      alu_rd    = 5'd6;
      alu_data  = 32'h0000_0066;
      settle();
      checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL rm_q_empty: got alu_ready=%b want 1", alu_ready); end
      step_edge();
      alu_valid = 1'b0;
      settle();
      checks++; if (we !== 1'b1 || outputReg !== 5'd6) begin errors++; $display("FAIL rm_alu_write: got we=%b reg=%0d want 1/6", we, outputReg); end
      step_edge();
   endtask

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < 600; i++) begin
         rst_n     = ($urandom_range(0, 79) != 0);
         alu_valid = ($urandom_range(0, 3) != 0);
         alu_rd    = REG_ADDR_W'($urandom_range(0, 31));
         alu_data  = $urandom;
         lsu_valid = ($urandom_range(0, 2) != 0);
         lsu_rd    = REG_ADDR_W'($urandom_range(0, 31));
         lsu_data  = $urandom;
         iss_valid = ($urandom_range(0, 1) != 0);
         iss_rd    = REG_ADDR_W'($urandom_range(0, 31));
         settle();
         checks++; if (alu_ready !== m_alu_rdy) begin errors++; $display("FAIL rnd_alu_ready cyc %0d: got %b want %b", i, alu_ready, m_alu_rdy); end
         checks++; if (lsu_ready !== m_lsu_rdy) begin errors++; $display("FAIL rnd_lsu_ready cyc %0d: got %b want %b", i, lsu_ready, m_lsu_rdy); end
         checks++; if (we !== m_we) begin errors++; $display("FAIL rnd_we cyc %0d: got %b want %b", i, we, m_we); end
         checks++; if (outputReg !== m_reg) begin errors++; $display("FAIL rnd_outputReg cyc %0d: got %0d want %0d", i, outputReg, m_reg); end
         checks++; if (data !== m_data) begin errors++; $display("FAIL rnd_data cyc %0d: got %h want %h", i, data, m_data); end
         checks++; if (busy !== m_busy) begin errors++; $display("FAIL rnd_busy cyc %0d: got %h want %h", i, busy, m_busy); end
         step_edge();
      end
      rst_n = 1'b1;
      drive_idle();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_alu_only();
      test_queue_fill();
      test_rd_zero();
      test_set_clear();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
